// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe: operand side in, result side out.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             red_and;
  logic             red_or;
  logic             red_xor;
  logic [WIDTH-1:0] acc;

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, y, red_and, red_or, red_xor, acc
  );

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, y, red_and, red_or, red_xor, acc
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic stage with XOR-accumulate mode and valid/ready on both sides.
module logic_unit_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] res;
  logic             in_ready;
  logic             xfer_in;
  logic             xfer_out;

  // No skid buffer: a new operand set is only taken when the result slot frees up.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign xfer_in  = bus.in_valid && in_ready;
  assign xfer_out = out_valid_q && bus.out_ready;

  always_comb begin
    acc_base = bus.acc_clr ? ACC_INIT : acc_q;
    res      = '0;
    case (bus.op)
      3'd0: res = bus.a & bus.b;
      3'd1: res = bus.a | bus.b;
      3'd2: res = bus.a ^ bus.b;
      3'd3: res = ~bus.a;
      3'd4: res = ~(bus.a & bus.b);
      3'd5: res = ~(bus.a | bus.b);
      3'd6: res = ~(bus.a ^ bus.b);
      3'd7: res = acc_base ^ bus.a;
      default: res = '0;
    endcase
  end

  always_comb begin
    y_d         = y_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    red_and_d   = red_and_q;
    red_or_d    = red_or_q;
    red_xor_d   = red_xor_q;
    if (xfer_in) begin
      y_d         = res;
      red_and_d   = &res;
      red_or_d    = |res;
      red_xor_d   = ^res;
      out_valid_d = 1'b1;
      if (bus.op == 3'd7) begin
        acc_d = res;
      end else if (bus.acc_clr) begin
        acc_d = ACC_INIT;
      end
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      acc_q       <= ACC_INIT;
      out_valid_q <= 1'b0;
      red_and_q   <= 1'b0;
      red_or_q    <= 1'b0;
      red_xor_q   <= 1'b0;
    end else begin
      y_q         <= y_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      red_and_q   <= red_and_d;
      red_or_q    <= red_or_d;
      red_xor_q   <= red_xor_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.red_and   = red_and_q;
  assign bus.red_or    = red_or_q;
  assign bus.red_xor   = red_xor_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: driver pushes modelled results, monitor pops and compares.
module tb_logic_unit_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus();

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic         ra;
    logic         ro;
    logic         rx;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] acc_m = '0;
  int           total = 0;
  int           bad = 0;
  int           or_mode = 0;
  bit           mon_on = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] v);
    exp_t r;
    int   ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(v[i]);
    r.y  = v;
    r.ra = (ones == W);
    r.ro = (ones > 0);
    r.rx = (ones % 2) == 1;
    return r;
  endfunction

  function automatic logic [W-1:0] gate(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  // Consumer readiness changes just after each rising edge so it is stable at the sampling points.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(9) < 7);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mon_on) begin
        chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        chk("out_valid_vs_sb", bus.out_valid, q.size() > 0);
        chk("acc", bus.acc, acc_m);
        if (bus.out_valid && q.size() > 0) begin
          chk("y", bus.y, q[0].y);
          chk("red_and", bus.red_and, q[0].ra);
          chk("red_or", bus.red_or, q[0].ro);
          chk("red_xor", bus.red_xor, q[0].rx);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic clr, output int waits);
    bit           done;
    logic         rdy;
    logic [W-1:0] r;
    done  = 0;
    waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.acc_clr  = clr;
    while (!done) begin
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        if (op == 3'd7) begin
          r     = (clr ? 8'h00 : acc_m) ^ a;
          acc_m = r;
        end else begin
          r = gate(op, a, b);
          if (clr) acc_m = 8'h00;
        end
        q.push_back(mk(r));
        done = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          chk("send_timeout", 1, 0);
          bus.in_valid = 1'b0;
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.acc_clr  = clr;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.op       = 3'($urandom);
    end
  endtask

  initial begin
    int               w;
    logic [W-1:0]     sweep_b;
    bus.in_valid = 1'b0;
    bus.op       = 3'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.acc_clr  = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_red", {bus.red_and, bus.red_or, bus.red_xor}, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #11 rst_n = 1'b1;
    mon_on = 1;

    // Single op, one-cycle latency, then the valid drops.
    or_mode = 0;
    send(3'd0, 8'hF0, 8'h3C, 1'b0, w);
    idle(1, 1'b0);
    #1;
    chk("single_y", bus.y, 8'h30);
    chk("single_ov", bus.out_valid, 1);
    chk("single_reds", {bus.red_and, bus.red_or, bus.red_xor}, 3'b010);
    idle(1, 1'b0);
    #1;
    chk("single_ov_drop", bus.out_valid, 0);

    // Full-rate sweep of ops 0..6.
    sweep_b = 8'h0F;
    for (int k = 0; k < 7; k++) begin
      send(3'(k), 8'hA5, sweep_b, 1'b0, w);
      chk("sweep_no_stall", w, 0);
    end
    idle(2, 1'b0);

    // Backpressure: hold the result, then release and accept on the same edge.
    or_mode = 2;
    idle(1, 1'b0);
    send(3'd1, 8'h11, 8'h22, 1'b0, w);
    fork
      send(3'd2, 8'h33, 8'h44, 1'b1, w);
      begin
        repeat (4) @(posedge clk);
        or_mode = 0;
      end
    join
    chk("bp_waited", w >= 3, 1);
    idle(2, 1'b0);

    // Accumulate chain and clears.
    send(3'd0, 8'h00, 8'h00, 1'b1, w);
    send(3'd7, 8'h01, 8'hFF, 1'b0, w);
    send(3'd7, 8'h02, 8'hFF, 1'b0, w);
    send(3'd7, 8'h04, 8'hFF, 1'b0, w);
    idle(1, 1'b0);
    #1 chk("acc_chain", bus.acc, 8'h07);
    send(3'd7, 8'h08, 8'h00, 1'b1, w);
    idle(1, 1'b0);
    #1 chk("acc_clr_op7", bus.acc, 8'h08);
    send(3'd0, 8'h55, 8'hAA, 1'b1, w);
    idle(1, 1'b0);
    #1 chk("acc_clr_op0", bus.acc, 8'h00);
    send(3'd7, 8'h07, 8'h00, 1'b0, w);
    idle(3, 1'b1);
    #1 chk("acc_clr_no_xfer", bus.acc, 8'h07);
    idle(1, 1'b0);

    // Reset while a result is stalled.
    or_mode = 2;
    idle(1, 1'b0);
    send(3'd7, 8'h00, 8'h00, 1'b0, w);
    idle(2, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_ov", bus.out_valid, 0);
    chk("async_rst_acc", bus.acc, 8'h00);
    q.delete();
    acc_m = 8'h00;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    or_mode = 0;
    send(3'd1, 8'hFF, 8'h00, 1'b0, w);
    idle(1, 1'b0);
    #1 chk("after_rst_y", bus.y, 8'hFF);
    send(3'd3, 8'hFE, 8'h00, 1'b0, w);
    idle(1, 1'b0);
    #1 chk("not_reds", {bus.y, bus.red_and, bus.red_or, bus.red_xor}, {8'h01, 3'b011});

    // Random traffic with random consumer stalls.
    or_mode = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3), 1'($urandom_range(1)));
      send(3'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(3) == 0), w);
    end
    or_mode = 0;
    idle(5, 1'b0);
    chk("sb_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end
endmodule
